// File: rtl/oscill_nios_pio_pkg.sv
// Shared constants for the Nios PIO output generator: register addresses and STATUS bit layout.
package oscill_nios_pio_pkg;

  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA       = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_BLINK_MASK = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS     = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET     = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR   = 3'd5;

  localparam int unsigned STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/oscill_nios_pio_blink_tick.sv
// Blink period counter: phase toggles every period+1 cycles; a load or a zero period parks it at cnt=0, phase=1.
module oscill_nios_pio_blink_tick #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                load,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt;

  // Load wins over terminal count; cnt never passes period so it cannot overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (load || (period == '0)) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == period) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/oscill_nios_pio_out_gen.sv
// Avalon-MM PIO output block with DATA/OUTSET/OUTCLEAR and an optional per-bit blink engine.
// Define OSCILL_PIO_BLINK_EN to build BLINK_MASK, PERIOD, STATUS and the blink counter.
module oscill_nios_pio_out_gen
  import oscill_nios_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 10,
  parameter int unsigned      PERIOD_W    = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_c;
  logic [WIDTH-1:0] wd_c;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] out_next_c;
  logic             unused_wd;

  assign wr_c      = chipselect & ~write_n;
  assign wd_c      = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  // DATA with single-cycle atomic set/clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
    end else if (wr_c) begin
      case (address)
        ADDR_DATA:     data <= wd_c;
        ADDR_OUTSET:   data <= data | wd_c;
        ADDR_OUTCLEAR: data <= data & ~wd_c;
        default:       data <= data;
      endcase
    end
  end

`ifdef OSCILL_PIO_BLINK_EN
  logic [WIDTH-1:0]    blink_mask;
  logic [PERIOD_W-1:0] period;
  logic                period_load_c;
  logic                phase;

  assign period_load_c = wr_c && (address == ADDR_PERIOD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask <= '0;
      period     <= '0;
    end else if (wr_c) begin
      if (address == ADDR_BLINK_MASK) blink_mask <= wd_c;
      if (address == ADDR_PERIOD)     period     <= writedata[PERIOD_W-1:0];
    end
  end

  oscill_nios_pio_blink_tick #(
    .PERIOD_W (PERIOD_W)
  ) u_blink_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period),
    .load    (period_load_c),
    .phase   (phase)
  );

  // Masked bits are gated by phase; unmasked bits follow DATA.
  assign out_next_c = (data & ~blink_mask) | (data & blink_mask & {WIDTH{phase}});

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:       readdata = 32'(data);
      ADDR_BLINK_MASK: readdata = 32'(blink_mask);
      ADDR_PERIOD:     readdata = 32'(period);
      ADDR_STATUS:     readdata[STATUS_PHASE_BIT] = phase;
      default:         readdata = '0;
    endcase
  end
`else
  assign out_next_c = data;

  always_comb begin
    readdata = '0;
    if (address == ADDR_DATA) readdata = 32'(data);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= RESET_VALUE;
    else          out_port <= out_next_c;
  end

endmodule

// File: tb/tb_oscill_nios_pio_out_gen.sv
// Scoreboard bench for oscill_nios_pio_out_gen; blink scenarios run only when OSCILL_PIO_BLINK_EN is defined.
`timescale 1ns/1ps
module tb_oscill_nios_pio_out_gen;
  import oscill_nios_pio_pkg::*;

  localparam logic [9:0] RV = 10'h155;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  oscill_nios_pio_out_gen #(
    .WIDTH       (10),
    .PERIOD_W    (24),
    .RESET_VALUE (RV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  // Phase after edge j counted from a PERIOD=3 load at edge 0; before the load phase is 1.
  function automatic bit ph3(input int j);
    return (j < 0) ? 1'b1 : (((j / 4) % 2) == 0);
  endfunction

  task automatic test_reset();
    logic [31:0] obs;
    sb_t e;
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    #1 reset_n = 1'b0;
    #1;
    push("reset_out_async", 32'(RV));
    e = sb_q.pop_front(); obs = 32'(out_port); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    push("reset_out", 32'(RV));
    @(negedge clk);
    e = sb_q.pop_front(); obs = 32'(out_port); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    push("reset_rd_data", 32'(RV));
`ifdef OSCILL_PIO_BLINK_EN
    push("reset_rd_status", 32'd1);
`else
    push("reset_rd_status", 32'd0);
`endif
    push("reset_rd_mask", 32'd0);
    push("reset_rd_period", 32'd0);
    rd(ADDR_DATA, obs);
    e = sb_q.pop_front(); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    rd(ADDR_STATUS, obs);
    e = sb_q.pop_front(); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    rd(ADDR_BLINK_MASK, obs);
    e = sb_q.pop_front(); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    rd(ADDR_PERIOD, obs);
    e = sb_q.pop_front(); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
  endtask

  task automatic test_data_ops();
    logic [31:0] obs;
    sb_t e;
    wr(ADDR_DATA, 32'h0F0);
    wr(ADDR_OUTSET, 32'h003);
    wr(ADDR_OUTCLEAR, 32'h010);
    push("dataops_out_lag", 32'h0F3);
    push("dataops_out", 32'h0E3);
    push("dataops_rd_data", 32'h0E3);
    @(negedge clk);
    e = sb_q.pop_front(); obs = 32'(out_port); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    @(negedge clk);
    e = sb_q.pop_front(); obs = 32'(out_port); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    rd(ADDR_DATA, obs);
    e = sb_q.pop_front(); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
  endtask

  task automatic test_reserved();
    logic [31:0] obs;
    sb_t e;
    wr(ADDR_STATUS, 32'hFFFF_FFFF);
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    push("reserved_rd_data", 32'h0E3);
    push("reserved_rd_6", 32'd0);
    push("reserved_rd_7", 32'd0);
    push("reserved_out", 32'h0E3);
    rd(ADDR_DATA, obs);
    e = sb_q.pop_front(); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    rd(3'd6, obs);
    e = sb_q.pop_front(); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    rd(3'd7, obs);
    e = sb_q.pop_front(); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    @(negedge clk);
    e = sb_q.pop_front(); obs = 32'(out_port); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
  endtask

`ifdef OSCILL_PIO_BLINK_EN
  task automatic test_blink();
    logic [31:0] obs;
    sb_t e;
    wr(ADDR_DATA, 32'h3FF);
    wr(ADDR_BLINK_MASK, 32'h00F);
    wr(ADDR_PERIOD, 32'd3);
    // Negedge m lies between edges m-1 and m; out_port carries the phase from edge m-2.
    for (int m = 1; m <= 16; m++) push($sformatf("blink_out_m%0d", m), ph3(m - 2) ? 32'h3FF : 32'h3F0);
    for (int m = 1; m <= 16; m++) begin
      @(negedge clk);
      e = sb_q.pop_front(); obs = 32'(out_port); n_tests++;
      if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    end
  endtask

  task automatic test_period_rewrite();
    logic [31:0] obs;
    sb_t e;
    bit ph_s, ph_o;
    int js, jo;
    wr(ADDR_DATA, 32'h3FF);
    wr(ADDR_BLINK_MASK, 32'h00F);
    wr(ADDR_PERIOD, 32'd3);
    repeat (21) @(negedge clk);
    push("rewrite_status_before", 32'(ph3(21)));
    rd(ADDR_STATUS, obs);
    e = sb_q.pop_front(); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    // This write lands on edge 23, where cnt==2 and phase==0.
    wr(ADDR_PERIOD, 32'd5);
    for (int m = 1; m <= 14; m++) begin
      js = 22 + m;
      jo = 21 + m;
      ph_s = (js < 23) ? ph3(js) : ((((js - 23) / 6) % 2) == 0);
      ph_o = (jo < 23) ? ph3(jo) : ((((jo - 23) / 6) % 2) == 0);
      push($sformatf("rewrite_status_m%0d", m), 32'(ph_s));
      push($sformatf("rewrite_out_m%0d", m), ph_o ? 32'h3FF : 32'h3F0);
    end
    address = ADDR_STATUS; chipselect = 1'b1; write_n = 1'b1;
    for (int m = 1; m <= 14; m++) begin
      @(negedge clk);
      e = sb_q.pop_front(); obs = readdata; n_tests++;
      if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
      e = sb_q.pop_front(); obs = 32'(out_port); n_tests++;
      if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    end
    chipselect = 1'b0;
  endtask

  task automatic test_reset_mid_blink();
    logic [31:0] obs;
    sb_t e;
    wr(ADDR_DATA, 32'h3FF);
    wr(ADDR_BLINK_MASK, 32'h00F);
    wr(ADDR_PERIOD, 32'd3);
    push("midreset_out_before", 32'h3F0);
    repeat (6) @(negedge clk);
    e = sb_q.pop_front(); obs = 32'(out_port); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    push("midreset_out_async", 32'(RV));
    push("midreset_rd_period", 32'd0);
    #2 reset_n = 1'b0;
    #1;
    e = sb_q.pop_front(); obs = 32'(out_port); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    address = ADDR_PERIOD;
    #1;
    e = sb_q.pop_front(); obs = readdata; n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int m = 1; m <= 6; m++) push($sformatf("midreset_out_after_m%0d", m), 32'(RV));
    for (int m = 1; m <= 6; m++) begin
      @(negedge clk);
      e = sb_q.pop_front(); obs = 32'(out_port); n_tests++;
      if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    end
    push("midreset_rd_status", 32'd1);
    rd(ADDR_STATUS, obs);
    e = sb_q.pop_front(); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
  endtask
`else
  task automatic test_no_blink();
    logic [31:0] obs;
    sb_t e;
    wr(ADDR_BLINK_MASK, 32'hFFFF_FFFF);
    wr(ADDR_PERIOD, 32'hFFFF_FFFF);
    push("noblink_rd_period", 32'd0);
    push("noblink_rd_mask", 32'd0);
    push("noblink_rd_status", 32'd0);
    push("noblink_rd_data", 32'h0E3);
    rd(ADDR_PERIOD, obs);
    e = sb_q.pop_front(); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    rd(ADDR_BLINK_MASK, obs);
    e = sb_q.pop_front(); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    rd(ADDR_STATUS, obs);
    e = sb_q.pop_front(); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    rd(ADDR_DATA, obs);
    e = sb_q.pop_front(); n_tests++;
    if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    for (int m = 1; m <= 8; m++) push($sformatf("noblink_out_m%0d", m), 32'h0E3);
    for (int m = 1; m <= 8; m++) begin
      @(negedge clk);
      e = sb_q.pop_front(); obs = 32'(out_port); n_tests++;
      if (obs !== e.exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.exp); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_data_ops();
    test_reserved();
`ifdef OSCILL_PIO_BLINK_EN
    test_blink();
    test_period_rewrite();
    test_reset_mid_blink();
`else
    test_no_blink();
`endif
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: observed %0d entries left expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
